// File: rtl/lfsr_keystream_gen_if.sv
// Handshake bundle between the keystream generator and its controller / XOR scrambler.
// Latency: none (wires only). Backpressure: ks_ready stalls the keystream; seed_ready gates seeding.
// slave = generator side, master = controller/consumer side.
interface lfsr_keystream_gen_if #(
    parameter int WIDTH = 16
);
    logic             seed_valid;
    logic             seed_ready;
    logic [WIDTH-1:0] seed;
    logic             start;
    logic             abort;
    logic             ks_valid;
    logic             ks_ready;
    logic             ks_bit;
    logic             busy;
    logic             frame_done;
    logic             seed_err;

    modport master (
        output seed_valid, seed, start, abort, ks_ready,
        input  seed_ready, ks_valid, ks_bit, busy, frame_done, seed_err
    );

    modport slave (
        input  seed_valid, seed, start, abort, ks_ready,
        output seed_ready, ks_valid, ks_bit, busy, frame_done, seed_err
    );
endinterface

// File: rtl/lfsr_keystream_gen.sv
// Galois-LFSR keystream source issuing FRAME_LEN bits per frame to the XOR scrambler.
// Latency: start at edge k -> ks_valid from cycle k+1; ks_bit is lfsr[0], fully registered.
// Backpressure: ks_ready=0 holds lfsr/cnt and ks_bit; abort wins over a same-cycle transfer.
module lfsr_keystream_gen #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] POLY      = 16'hB400,
    parameter int               FRAME_LEN = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lfsr_keystream_gen_if.slave  ks_if
);

    localparam int            CW       = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] lfsr;
    logic [CW-1:0]    cnt;
    logic             seed_err_q;
    logic             seed_load;
    logic             xfer;

    assign seed_load = (state == IDLE) && ks_if.seed_valid;
    assign xfer      = (state == RUN) && ks_if.ks_ready && !ks_if.abort;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        ks_if.seed_ready = 1'b0;
        ks_if.ks_valid   = 1'b0;
        ks_if.busy       = 1'b0;
        ks_if.frame_done = 1'b0;
        ks_if.ks_bit     = lfsr[0];
        ks_if.seed_err   = seed_err_q;
        case (state)
            IDLE: begin
                ks_if.seed_ready = 1'b1;
                if (ks_if.start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                ks_if.ks_valid = 1'b1;
                ks_if.busy     = 1'b1;
                if (ks_if.abort) begin
                    state_nxt = IDLE;
                end else if (xfer && (cnt == LAST_CNT)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                ks_if.busy       = 1'b1;
                ks_if.frame_done = 1'b1;
                state_nxt        = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // An all-zero seed would lock the LFSR, so it is replaced by 1 and flagged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr       <= WIDTH'(1);
            cnt        <= '0;
            seed_err_q <= 1'b0;
        end else begin
            seed_err_q <= 1'b0;
            if (seed_load) begin
                if (ks_if.seed == '0) begin
                    lfsr       <= WIDTH'(1);
                    seed_err_q <= 1'b1;
                end else begin
                    lfsr <= ks_if.seed;
                end
            end else if (xfer) begin
                lfsr <= {1'b0, lfsr[WIDTH-1:1]} ^ (lfsr[0] ? POLY : '0);
            end

            if (((state == RUN) && ks_if.abort) || (state == DONE)) begin
                cnt <= '0;
            end else if (xfer) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_keystream_gen.sv
// Directed + randomized bench for lfsr_keystream_gen against a step-count LFSR reference.
// Inputs change 1 time unit after each rising edge; outputs are sampled at that same offset.
// Random ready patterns and seeds come from $urandom; the model tracks the expected LFSR state.
module tb_lfsr_keystream_gen;

    localparam int          WIDTH     = 16;
    localparam logic [15:0] POLY      = 16'hB400;
    localparam int          FRAME_LEN = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] m_lfsr;
    logic        obs_q[$];

    always #5 clk = ~clk;

    lfsr_keystream_gen_if #(.WIDTH(WIDTH)) ks_if ();

    lfsr_keystream_gen #(
        .WIDTH(WIDTH),
        .POLY(POLY),
        .FRAME_LEN(FRAME_LEN)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ks_if(ks_if)
    );

    // Register state after n transfers from x.
    function automatic logic [15:0] adv(input logic [15:0] x, input int n);
        logic [15:0] v;
        v = x;
        for (int i = 0; i < n; i++) begin
            v = (v >> 1) ^ (v[0] ? POLY : 16'h0000);
        end
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input bit load, input logic [15:0] s);
        ks_if.start      = 1'b1;
        ks_if.seed_valid = load;
        ks_if.seed       = s;
        step();
        ks_if.start      = 1'b0;
        ks_if.seed_valid = 1'b0;
        if (load) m_lfsr = (s == 16'h0000) ? 16'h0001 : s;
        chk("start_busy", ks_if.busy, 1);
        chk("start_seed_ready", ks_if.seed_ready, 0);
        chk("start_seed_err", ks_if.seed_err, (load && s == 16'h0000));
    endtask

    // mode 0: always ready, 1: ready toggles 1/0, 2: random ready. abort_at<0 disables abort.
    task automatic run_frame(input int mode, input int abort_at, input bit chk_b313);
        int   n;
        int   guard;
        logic rdy;
        logic prev;
        n     = 0;
        guard = 0;
        obs_q.delete();
        while (n < FRAME_LEN && guard < 1000) begin
            guard++;
            chk("ks_valid_run", ks_if.ks_valid, 1);
            chk("seed_ready_run", ks_if.seed_ready, 0);
            chk("ks_bit", ks_if.ks_bit, m_lfsr[0]);
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 1) rdy = guard[0];
            else                rdy = 1'($urandom_range(0, 1));
            if (n == abort_at) begin
                ks_if.abort = 1'b1;
                rdy         = 1'b1;
            end
            ks_if.ks_ready = rdy;
            prev           = ks_if.ks_bit;
            step();
            ks_if.ks_ready = 1'b0;
            if (n == abort_at) begin
                ks_if.abort = 1'b0;
                chk("abort_idle", ks_if.seed_ready, 1);
                chk("abort_busy", ks_if.busy, 0);
                chk("abort_no_done", ks_if.frame_done, 0);
                chk("abort_lfsr_kept", dut.lfsr, m_lfsr);
                return;
            end
            if (rdy) begin
                obs_q.push_back(prev);
                m_lfsr = adv(m_lfsr, 1);
                n++;
                if (chk_b313 && n == 6) chk("lfsr_after6", dut.lfsr, 16'hB313);
            end else begin
                chk("stall_hold", ks_if.ks_bit, prev);
            end
        end
        chk("frame_xfers", n, FRAME_LEN);
        chk("done_pulse", ks_if.frame_done, 1);
        chk("done_valid", ks_if.ks_valid, 0);
        chk("done_busy", ks_if.busy, 1);
        step();
        chk("done_clear", ks_if.frame_done, 0);
        chk("idle_busy", ks_if.busy, 0);
        chk("idle_seed_ready", ks_if.seed_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] s;
        logic [15:0] r;
        logic        exp6[6];
        exp6 = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        rst_n            = 1'b0;
        ks_if.seed_valid = 1'b0;
        ks_if.seed       = 16'h0000;
        ks_if.start      = 1'b0;
        ks_if.abort      = 1'b0;
        ks_if.ks_ready   = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        chk("rst_seed_ready", ks_if.seed_ready, 1);
        chk("rst_ks_valid", ks_if.ks_valid, 0);
        chk("rst_busy", ks_if.busy, 0);
        chk("rst_frame_done", ks_if.frame_done, 0);
        chk("rst_seed_err", ks_if.seed_err, 0);
        chk("rst_ks_bit", ks_if.ks_bit, 1);

        // Known-answer frame from seed ACE1.
        start_frame(1'b1, 16'hACE1);
        run_frame(0, -1, 1'b1);
        for (int i = 0; i < 6; i++) chk("ace1_bit", obs_q[i], exp6[i]);

        // Abort in IDLE is ignored.
        ks_if.abort = 1'b1;
        step();
        ks_if.abort = 1'b0;
        chk("idle_abort_busy", ks_if.busy, 0);
        chk("idle_abort_ready", ks_if.seed_ready, 1);

        // Stalling downstream: ready toggles every cycle.
        s = 16'($urandom_range(1, 65535));
        start_frame(1'b1, s);
        run_frame(1, -1, 1'b0);

        // All-zero seed loaded in IDLE.
        ks_if.seed_valid = 1'b1;
        ks_if.seed       = 16'h0000;
        step();
        ks_if.seed_valid = 1'b0;
        m_lfsr           = 16'h0001;
        chk("zero_seed_err", ks_if.seed_err, 1);
        chk("zero_seed_lfsr", dut.lfsr, 16'h0001);
        chk("zero_seed_idle", ks_if.busy, 0);
        step();
        chk("zero_seed_err_clear", ks_if.seed_err, 0);
        start_frame(1'b0, 16'h0000);
        chk("zero_seed_first_bit", ks_if.ks_bit, 1);
        run_frame(2, -1, 1'b0);

        // Abort after 10 transfers, then resume at bit 11.
        s = 16'($urandom_range(1, 65535));
        start_frame(1'b1, s);
        run_frame(0, 10, 1'b0);
        start_frame(1'b0, 16'h0000);
        r = adv(s, 10);
        chk("restart_bit11", ks_if.ks_bit, r[0]);
        run_frame(2, -1, 1'b0);

        // Abort coinciding with the final transfer: abort wins.
        start_frame(1'b0, 16'h0000);
        run_frame(0, FRAME_LEN - 1, 1'b0);

        // Back-to-back frames without reseed; seed offers during RUN are ignored.
        s = 16'($urandom_range(1, 65535));
        start_frame(1'b1, s);
        run_frame(0, -1, 1'b0);
        start_frame(1'b0, 16'h0000);
        r = adv(s, 64);
        chk("frame2_bit65", ks_if.ks_bit, r[0]);
        ks_if.seed_valid = 1'b1;
        ks_if.seed       = 16'($urandom);
        run_frame(2, -1, 1'b0);
        ks_if.seed_valid = 1'b0;

        // Seed and start in the same IDLE cycle with a random seed, random readiness.
        for (int k = 0; k < 3; k++) begin
            s = 16'($urandom);
            start_frame(1'b1, s);
            run_frame(2, -1, 1'b0);
        end

        // Reset in the middle of a frame.
        s = 16'($urandom_range(1, 65535));
        start_frame(1'b1, s);
        ks_if.ks_ready = 1'b1;
        repeat (5) step();
        ks_if.ks_ready = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        m_lfsr = 16'h0001;
        chk("midrst_ks_valid", ks_if.ks_valid, 0);
        chk("midrst_busy", ks_if.busy, 0);
        chk("midrst_seed_ready", ks_if.seed_ready, 1);
        chk("midrst_lfsr", dut.lfsr, 16'h0001);
        chk("midrst_frame_done", ks_if.frame_done, 0);
        start_frame(1'b0, 16'h0000);
        run_frame(2, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
